secuenciador_mux4: RTL and testbench
====================================

Name: secuenciador_mux4

Overview:
- Round-robin channel sequencer that sits directly upstream of the 4-to-1 multiplexer.
- Arbitrates four per-channel requests and drives the mux Selector.
- Samples the mux output (Salida) back in on Dato and registers it, with a valid strobe, for the downstream consumer.
- Bounds each grant to a maximum burst length so no channel starves the others.

Parameters:
- ANCHO, 3, data width of Dato/DatoSalida; matches the mux data width.
- RAFAGA_MAX, 4, maximum beats per grant; legal range 1..15.

Ports:
- Reloj  input  1  single system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Solicitud  input  4  per-channel request; bit i = channel i (A=0, B=1, C=2, D=3).
- Dato  input  ANCHO  mux output (Salida) fed back for capture.
- Selector  output  3  mux select; only 000..011 are ever driven, so bit 2 is always 0.
- Concesion  output  4  one-hot grant; 0000 when idle.
- Ocupado  output  1  high while a channel is granted.
- DatoSalida  output  ANCHO  registered captured data.
- Valido  output  1  high for each cycle in which DatoSalida holds a new beat.

Behaviour:
- Reset (asynchronous, immediate, active-high):
  - Outputs: Selector=000, Concesion=0000, Ocupado=0, DatoSalida=0, Valido=0.
  - Internal: Ultimo=3 (so channel 0 has first priority), Contador=0, state REPOSO.
  - Asserting Reset mid-burst aborts the burst; no partial-beat Valido is produced.
- States: REPOSO, CONCEDIDO.
- Arbitration function: search channels Ultimo+1, Ultimo+2, Ultimo+3, Ultimo+4 (all mod 4) and pick the first with Solicitud set. The last candidate is Ultimo itself, so a lone requester is re-granted.
- REPOSO:
  - If Solicitud==0000, stay in REPOSO with Valido=0.
  - Otherwise, at the edge: pick a channel by arbitration, set canal/Selector/Concesion, Ocupado=1, Contador=0, Ultimo=canal, and go to CONCEDIDO.
  - Latency: request sampled at edge k gives grant visible after edge k; first Valido after edge k+1.
- CONCEDIDO, each edge:
  - Beat condition: Solicitud[canal]=1. On a beat, DatoSalida<=Dato and Valido<=1 (one cycle of latency from Selector to DatoSalida).
  - No beat (request dropped): Valido<=0 and the grant is released at this edge.
  - Last beat: Contador==RAFAGA_MAX-1 on a beat. The beat is captured and the grant is released at the same edge.
  - Otherwise, on a beat: Contador<=Contador+1.
- Release (at a single edge):
  - Re-arbitrate with Ultimo=canal.
  - If a requester is found: switch directly to it with no idle cycle. Selector/Concesion change, Contador=0, stay in CONCEDIDO, Ocupado stays 1.
  - If none is found: go to REPOSO with Selector=000, Concesion=0000, Ocupado=0.
- Valido vs. release: Valido reflects only the beat captured at that edge, independent of state change. It is 0 in REPOSO except for the cycle right after a last beat.
- Other requests: changes on non-granted channels never affect the current grant.
- Invariants:
  - Concesion is one-hot or zero.
  - Concesion == (1 << Selector) when Ocupado=1.
  - Ocupado == |Concesion.
- Dato is treated as combinational from Selector; no check is made on its value.

Test Plan:
- Reset and idle: Reset=1 then 0, Solicitud=0000 for 10 cycles → Selector=000, Concesion=0000, Ocupado=0, Valido=0, DatoSalida=000 throughout.
- Capture path: model the mux with A=001, B=100, C=101, D=110 and hold Solicitud=1111 with RAFAGA_MAX=4 → grants run ch0,1,2,3,0 with 4 beats each and no gaps. Selector steps 000→001→010→011→000. DatoSalida is 001×4, 100×4, 101×4, 110×4, each lagging Selector by one cycle. Valido=1 continuously.
- Lone requester: Solicitud=0100 continuous → ch2 is re-granted every 4 beats with no idle cycle. Concesion stays 0100 and Valido stays 1.
- Early drop: Solicitud=0011, then clear bit 0 after 2 beats of ch0 → exactly 2 Valido beats with DatoSalida=001. At the drop edge the grant moves to ch1 (Concesion=0010) and Valido=0 for one cycle before the first ch1 beat.
- Burst of one: RAFAGA_MAX=1, Solicitud=1010 → grants alternate ch1, ch3, ch1, ch3 each cycle. DatoSalida alternates 100, 110.
- Reset mid-burst: assert Reset asynchronously during beat 2 of ch1 → all outputs go to 0 immediately without waiting for an edge. After release with Solicitud=1111, ch0 is granted first.

Source files
------------

// File: rtl/secuenciador_mux4.sv
// Round-robin sequencer in front of a 4-to-1 mux: arbitrates four requests,
// drives the mux select, and registers the fed-back mux output with a valid strobe.
module secuenciador_mux4 #(
  parameter int ANCHO      = 3,
  parameter int RAFAGA_MAX = 4
) (
  input  logic             Reloj,
  input  logic             Reset,
  input  logic [3:0]       Solicitud,
  input  logic [ANCHO-1:0] Dato,
  output logic [2:0]       Selector,
  output logic [3:0]       Concesion,
  output logic             Ocupado,
  output logic [ANCHO-1:0] DatoSalida,
  output logic             Valido
);

  typedef enum logic {REPOSO, CONCEDIDO} estado_t;

  localparam logic [3:0] ULTIMO_BEAT = 4'(RAFAGA_MAX - 1);

  estado_t          estado, estado_sig;
  logic [1:0]       canal, canal_sig;
  logic [1:0]       ultimo, ultimo_sig;
  logic [3:0]       contador, contador_sig;
  logic [ANCHO-1:0] dato_p0, dato_sig;
  logic             vld_p0, vld_sig;
  logic [2:0]       arb;

  // Returns {found, channel}; offsets scanned high to low so the nearest
  // successor of ult wins, with ult itself as the final candidate.
  function automatic logic [2:0] arbitrar(input logic [1:0] ult, input logic [3:0] sol);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      cand = ult + 2'(i);
      if (sol[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // ultimo always equals canal while a grant is held, so one arbiter serves both states
  assign arb = arbitrar(ultimo, Solicitud);

  always_comb begin
    estado_sig   = estado;
    canal_sig    = canal;
    ultimo_sig   = ultimo;
    contador_sig = contador;
    dato_sig     = dato_p0;
    vld_sig      = 1'b0;
    case (estado)
      REPOSO: begin
        if (arb[2]) begin
          estado_sig   = CONCEDIDO;
          canal_sig    = arb[1:0];
          ultimo_sig   = arb[1:0];
          contador_sig = 4'd0;
        end
      end
      CONCEDIDO: begin
        if (Solicitud[canal]) begin
          dato_sig = Dato;
          vld_sig  = 1'b1;
        end
        if (!Solicitud[canal] || contador == ULTIMO_BEAT) begin
          if (arb[2]) begin
            canal_sig    = arb[1:0];
            ultimo_sig   = arb[1:0];
            contador_sig = 4'd0;
          end else begin
            estado_sig = REPOSO;
          end
        end else begin
          contador_sig = contador + 4'd1;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Stage p0: grant state and captured beat
  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      estado   <= REPOSO;
      canal    <= 2'd0;
      ultimo   <= 2'd3;
      contador <= 4'd0;
      dato_p0  <= '0;
      vld_p0   <= 1'b0;
    end else begin
      estado   <= estado_sig;
      canal    <= canal_sig;
      ultimo   <= ultimo_sig;
      contador <= contador_sig;
      dato_p0  <= dato_sig;
      vld_p0   <= vld_sig;
    end
  end

  assign Ocupado    = (estado == CONCEDIDO);
  assign Selector   = Ocupado ? {1'b0, canal} : 3'b000;
  assign Concesion  = Ocupado ? (4'b0001 << canal) : 4'b0000;
  assign DatoSalida = dato_p0;
  assign Valido     = vld_p0;

endmodule

// File: tb/tb_secuenciador_mux4.sv
// Scoreboard bench for secuenciador_mux4: one instance with bursts of 4,
// one with bursts of 1, each feeding back a modelled 4-to-1 mux.
module tb_secuenciador_mux4;
  localparam int ANCHO = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       sol, sol1;
  logic [ANCHO-1:0] dato, dato1;
  logic [2:0]       sel, sel1;
  logic [3:0]       conc, conc1;
  logic             ocup, ocup1, vld, vld1;
  logic [ANCHO-1:0] dsal, dsal1;

  int pasadas = 0;
  int totales = 0;
  logic [ANCHO-1:0] q0[$];
  logic [ANCHO-1:0] q1[$];

  always #5 clk = ~clk;

  function automatic logic [ANCHO-1:0] mux(input logic [2:0] s);
    case (s[1:0])
      2'd0:    return 3'b001;
      2'd1:    return 3'b100;
      2'd2:    return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  assign dato  = mux(sel);
  assign dato1 = mux(sel1);

  secuenciador_mux4 #(.ANCHO(ANCHO), .RAFAGA_MAX(4)) u_dut (
    .Reloj(clk), .Reset(rst), .Solicitud(sol), .Dato(dato),
    .Selector(sel), .Concesion(conc), .Ocupado(ocup),
    .DatoSalida(dsal), .Valido(vld)
  );

  secuenciador_mux4 #(.ANCHO(ANCHO), .RAFAGA_MAX(1)) u_dut1 (
    .Reloj(clk), .Reset(rst), .Solicitud(sol1), .Dato(dato1),
    .Selector(sel1), .Concesion(conc1), .Ocupado(ocup1),
    .DatoSalida(dsal1), .Valido(vld1)
  );

  task automatic chk(input string nombre, input int act, input int exp);
    totales++;
    if (act == exp) pasadas++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nombre, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every valid beat and checks grant invariants
  always @(negedge clk) begin
    if (vld) begin
      if (q0.size() == 0) begin
        totales++;
        $display("FAIL r4 unexpected beat: got %0d, expected none at %0t", dsal, $time);
      end else chk("r4 beat", int'(dsal), int'(q0.pop_front()));
    end
    if (vld1) begin
      if (q1.size() == 0) begin
        totales++;
        $display("FAIL r1 unexpected beat: got %0d, expected none at %0t", dsal1, $time);
      end else chk("r1 beat", int'(dsal1), int'(q1.pop_front()));
    end
    chk("r4 ocupado", int'(ocup), int'(|conc));
    chk("r4 onehot", int'(conc), ocup ? (int'(1) << sel) : 0);
    chk("r1 ocupado", int'(ocup1), int'(|conc1));
    chk("r1 onehot", int'(conc1), ocup1 ? (int'(1) << sel1) : 0);
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    sol  = 4'b0000;
    sol1 = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    // Reset and idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle r4", int'({sel, conc, ocup, dsal, vld}), 0);
      chk("idle r1", int'({sel1, conc1, ocup1, dsal1, vld1}), 0);
    end

    // Capture path: all four requesting, bursts of 4
    sol = 4'b1111;
    for (int b = 0; b < 20; b++) q0.push_back(mux(3'((b / 4) % 4)));
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i % 4 == 1) chk("rr selector", int'(sel), ((i - 1) / 4) % 4);
      if (i >= 2) chk("rr valido", int'(vld), 1);
    end
    sol = 4'b0000;
    ciclos(2);
    chk("rr idle", int'(ocup), 0);
    chk("rr drained", q0.size(), 0);

    // Lone requester on channel 2
    sol = 4'b0100;
    for (int b = 0; b < 8; b++) q0.push_back(3'b101);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("lone concesion", int'(conc), 4);
      if (i >= 2) chk("lone valido", int'(vld), 1);
    end
    sol = 4'b0000;
    ciclos(2);
    chk("lone idle", int'(ocup), 0);
    chk("lone drained", q0.size(), 0);

    // Early drop of channel 0 after two beats
    sol = 4'b0011;
    q0.push_back(3'b001);
    q0.push_back(3'b001);
    for (int b = 0; b < 4; b++) q0.push_back(3'b100);
    @(negedge clk);
    chk("drop first grant", int'(conc), 1);
    ciclos(2);
    sol = 4'b0010;
    @(negedge clk);
    chk("drop switch", int'(conc), 2);
    chk("drop gap", int'(vld), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drop ch1 valido", int'(vld), 1);
    end
    sol = 4'b0000;
    ciclos(2);
    chk("drop idle", int'(ocup), 0);
    chk("drop drained", q0.size(), 0);

    // Burst of one: channels 1 and 3 alternate every cycle
    sol1 = 4'b1010;
    for (int b = 0; b < 3; b++) begin
      q1.push_back(3'b100);
      q1.push_back(3'b110);
    end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i <= 6) chk("b1 concesion", int'(conc1), (i % 2 == 1) ? 2 : 8);
      if (i >= 2) chk("b1 valido", int'(vld1), 1);
    end
    sol1 = 4'b0000;
    ciclos(2);
    chk("b1 idle", int'(ocup1), 0);
    chk("b1 drained", q1.size(), 0);

    // Asynchronous reset in the middle of a channel 1 burst
    sol = 4'b0010;
    q0.push_back(3'b100);
    @(negedge clk);
    chk("mid grant", int'(conc), 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("mid async reset", int'({sel, conc, ocup, dsal, vld}), 0);
    sol = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post reset grant", int'(conc), 1);
    chk("post reset valido", int'(vld), 0);
    sol = 4'b0000;
    ciclos(2);
    chk("post reset idle", int'(ocup), 0);
    chk("post reset drained", q0.size(), 0);

    $display("%0d/%0d checks passed", pasadas, totales);
    $finish;
  end

endmodule
